sim_result_monitor: RTL and testbench
=====================================

# sim_result_monitor

Synthesizable end-of-test monitor that sits downstream of the CPU's data-memory write port, alongside the data memory. It watches every store the single-cycle core issues, decides pass/fail when the program writes its signature word, and flags a timeout if no signature store arrives within a cycle budget. Benches and FPGA builds read one sticky verdict instead of peeking into RAM after a fixed delay.

## Interface
- SIG_ADDR, 32'd84: byte address of the signature word. It must be word-aligned (RAM index 21).
- EXPECT, 32'd8: signature value that means pass.
- TIMEOUT_CYCLES, 1000: cycles after reset release before a timeout is declared. Must be ≥ 1.
- CNT_W, 16: width of the store counter.
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- MemWrite  input  1  store strobe from the core, qualified on the same edge as the data memory write.
- DataAdr  input  32  byte address of the access.
- WriteData  input  32  store data.
- done  output  1  a verdict has been reached (PASS, FAIL or TIMEOUT); sticky.
- pass  output  1  signature matched EXPECT; sticky.
- fail  output  1  signature store carried a value other than EXPECT; sticky.
- timeout  output  1  cycle budget expired with no signature store; sticky.
- sig_value  output  32  data captured from the signature store.
- store_count  output  CNT_W  stores observed while in RUN; saturates at all-ones.
- misaligned  output  1  sticky; set by any store in RUN with DataAdr[1:0] ≠ 0.

## Operation
- FSM states and encodings: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are terminal and exit only on reset.
- Reset: state = RUN, cycle_cnt = 0, and every output = 0 (done, pass, fail, timeout, sig_value, store_count, misaligned).
- RUN, each cycle with reset low:
  - cycle_cnt increments.
  - If MemWrite = 1, store_count increments (saturating) and misaligned is set when DataAdr[1:0] ≠ 0.
- Signature hit: MemWrite = 1 and DataAdr == SIG_ADDR, full 32-bit compare.
  - sig_value ← WriteData.
  - Go to PASS if WriteData == EXPECT; otherwise go to FAIL.
- Timeout: in RUN with no signature hit and cycle_cnt == TIMEOUT_CYCLES−1, go to TIMEOUT.
- Simultaneous events: a signature hit on the timeout cycle takes priority, so the state goes to PASS or FAIL and timeout stays 0.
- Terminal states:
  - cycle_cnt, store_count, misaligned and sig_value are frozen.
  - Later stores, including to SIG_ADDR, are ignored, so the first signature store wins.
- Outputs decode the state: pass = (PASS), fail = (FAIL), timeout = (TIMEOUT), done = pass | fail | timeout. Exactly one verdict bit can be high.
- cycle_cnt width: $clog2(TIMEOUT_CYCLES+1) bits, internal only.

## Timing
- All outputs are registered. A signature store sampled at edge N makes done/pass/fail/sig_value visible after edge N, i.e. one cycle of latency.
- Timeout: with reset deasserted before edge 0, timeout rises after edge TIMEOUT_CYCLES−1.
- store_count reflects stores up to and including the previous edge.
- Reset asserted mid-run or in a terminal state clears everything at the next edge. Counting restarts on the first edge with reset low.
- A store on the same edge as reset is not counted.
- No combinational path from inputs to outputs.

## Test plan
- Reset held 2 cycles, then three stores to 0x40, then a store of 8 to 84 → pass = 1 and done = 1 one cycle later; sig_value = 8; store_count = 4; fail = timeout = 0.
- Store of 7 to 84 → fail = 1, sig_value = 7. A later store of 8 to 84 leaves fail = 1, pass = 0, sig_value = 7 (first store wins).
- TIMEOUT_CYCLES = 20 with no store to 84 → timeout rises after edge 19. Stores after that do not change store_count.
- TIMEOUT_CYCLES = 20 with a store of 8 to 84 on the cycle where cycle_cnt = 19 → pass = 1, timeout = 0.
- Store to 0x55 (misaligned) → misaligned = 1; FSM stays in RUN. With CNT_W = 4, 20 stores → store_count = 15 (saturated).
- Reach PASS, assert reset for 1 cycle → all outputs 0. Rerun with a store of 8 to 84 → PASS again after 1 cycle.

Source files
------------

// File: rtl/sim_result_monitor.sv
// End-of-test monitor: watches core stores, latches a sticky pass/fail
// verdict on the signature store, or a timeout if none arrives in time.
module sim_result_monitor #(
   parameter logic [31:0] SIG_ADDR       = 32'd84,
   parameter logic [31:0] EXPECT         = 32'd8,
   parameter int          TIMEOUT_CYCLES = 1000,
   parameter int          CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             MemWrite,
   input  logic [31:0]      DataAdr,
   input  logic [31:0]      WriteData,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [31:0]      sig_value,
   output logic [CNT_W-1:0] store_count,
   output logic             misaligned
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_PASS = 2'd1;
   localparam logic [1:0] S_FAIL = 2'd2;
   localparam logic [1:0] S_TO   = 2'd3;

   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cycle_q, cycle_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic [31:0]      sig_q, sig_d;
   logic             mis_q, mis_d;
   logic             sig_hit;

   assign sig_hit = MemWrite && (DataAdr == SIG_ADDR);

   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      scnt_d  = scnt_q;
      sig_d   = sig_q;
      mis_d   = mis_q;
      if (state_q == S_RUN) begin
         cycle_d = cycle_q + CW'(1);
         if (MemWrite) begin
            if (scnt_q != '1)
               scnt_d = scnt_q + CNT_W'(1);
            if (DataAdr[1:0] != 2'b00)
               mis_d = 1'b1;
         end
         // A signature hit outranks a timeout landing on the same cycle
         if (sig_hit) begin
            sig_d   = WriteData;
            state_d = (WriteData == EXPECT) ? S_PASS : S_FAIL;
         end else if (cycle_q == TO_LAST) begin
            state_d = S_TO;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RUN;
         cycle_q <= '0;
         scnt_q  <= '0;
         sig_q   <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         scnt_q  <= scnt_d;
         sig_q   <= sig_d;
         mis_q   <= mis_d;
      end
   end

   assign pass        = (state_q == S_PASS);
   assign fail        = (state_q == S_FAIL);
   assign timeout     = (state_q == S_TO);
   assign done        = pass | fail | timeout;
   assign sig_value   = sig_q;
   assign store_count = scnt_q;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_sim_result_monitor.sv
// Directed bench for sim_result_monitor across three parameterisations.
module tb_sim_result_monitor;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // A: defaults; B: CNT_W=4; C: TIMEOUT_CYCLES=20
   logic        mwA, mwB, mwC;
   logic [31:0] adA, adB, adC, wdA, wdB, wdC;
   logic        doneA, passA, failA, toA, misA;
   logic        doneB, passB, failB, toB, misB;
   logic        doneC, passC, failC, toC, misC;
   logic [31:0] svA, svB, svC;
   logic [15:0] scA, scC;
   logic [3:0]  scB;

   sim_result_monitor uA (
      .clk(clk), .reset(reset), .MemWrite(mwA), .DataAdr(adA),
      .WriteData(wdA), .done(doneA), .pass(passA), .fail(failA),
      .timeout(toA), .sig_value(svA), .store_count(scA),
      .misaligned(misA));

   sim_result_monitor #(.CNT_W(4)) uB (
      .clk(clk), .reset(reset), .MemWrite(mwB), .DataAdr(adB),
      .WriteData(wdB), .done(doneB), .pass(passB), .fail(failB),
      .timeout(toB), .sig_value(svB), .store_count(scB),
      .misaligned(misB));

   sim_result_monitor #(.TIMEOUT_CYCLES(20)) uC (
      .clk(clk), .reset(reset), .MemWrite(mwC), .DataAdr(adC),
      .WriteData(wdC), .done(doneC), .pass(passC), .fail(failC),
      .timeout(toC), .sig_value(svC), .store_count(scC),
      .misaligned(misC));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic stA(input logic [31:0] a, input logic [31:0] d);
      mwA = 1'b1; adA = a; wdA = d;
      step();
      mwA = 1'b0;
   endtask

   initial begin
      mwA = 0; mwB = 0; mwC = 0;
      adA = 0; adB = 0; adC = 0;
      wdA = 0; wdB = 0; wdC = 0;

      // Reset with a store on the reset edge: must not count
      reset = 1'b1;
      mwA = 1'b1; adA = 32'h40;
      step();
      mwA = 1'b0;
      step();
      chk("rst_done", {31'b0, doneA}, 32'd0);
      chk("rst_pass", {31'b0, passA}, 32'd0);
      chk("rst_fail", {31'b0, failA}, 32'd0);
      chk("rst_to", {31'b0, toA}, 32'd0);
      chk("rst_sig", svA, 32'd0);
      chk("rst_cnt", {16'b0, scA}, 32'd0);
      chk("rst_mis", {31'b0, misA}, 32'd0);

      // Three ordinary stores then a passing signature
      reset = 1'b0;
      stA(32'h40, 32'h11);
      stA(32'h40, 32'h22);
      stA(32'h40, 32'h33);
      chk("pre_done", {31'b0, doneA}, 32'd0);
      chk("pre_cnt", {16'b0, scA}, 32'd3);
      stA(32'd84, 32'd8);
      chk("p_pass", {31'b0, passA}, 32'd1);
      chk("p_done", {31'b0, doneA}, 32'd1);
      chk("p_sig", svA, 32'd8);
      chk("p_cnt", {16'b0, scA}, 32'd4);
      chk("p_fail", {31'b0, failA}, 32'd0);
      chk("p_to", {31'b0, toA}, 32'd0);

      // Reset from PASS clears everything
      reset = 1'b1;
      step();
      chk("r2_done", {31'b0, doneA}, 32'd0);
      chk("r2_pass", {31'b0, passA}, 32'd0);
      chk("r2_sig", svA, 32'd0);
      chk("r2_cnt", {16'b0, scA}, 32'd0);

      // Rerun: passing signature again after one cycle
      reset = 1'b0;
      stA(32'd84, 32'd8);
      chk("rr_pass", {31'b0, passA}, 32'd1);
      chk("rr_cnt", {16'b0, scA}, 32'd1);

      // Failing signature; later good signature ignored
      reset = 1'b1;
      step();
      reset = 1'b0;
      stA(32'd84, 32'd7);
      chk("f_fail", {31'b0, failA}, 32'd1);
      chk("f_done", {31'b0, doneA}, 32'd1);
      chk("f_sig", svA, 32'd7);
      stA(32'd84, 32'd8);
      chk("f2_fail", {31'b0, failA}, 32'd1);
      chk("f2_pass", {31'b0, passA}, 32'd0);
      chk("f2_sig", svA, 32'd7);
      chk("f2_cnt", {16'b0, scA}, 32'd1);

      // Near-miss address is not a signature hit
      reset = 1'b1;
      step();
      reset = 1'b0;
      stA(32'd88, 32'd8);
      chk("nm_done", {31'b0, doneA}, 32'd0);
      chk("nm_mis", {31'b0, misA}, 32'd0);

      // B: misaligned store, then saturation at 15
      reset = 1'b1;
      step();
      reset = 1'b0;
      mwB = 1'b1; adB = 32'h55; wdB = 32'h1;
      step();
      chk("mis_set", {31'b0, misB}, 32'd1);
      chk("mis_done", {31'b0, doneB}, 32'd0);
      chk("mis_cnt", {28'b0, scB}, 32'd1);
      adB = 32'h40;
      for (int i = 0; i < 13; i++) step();
      chk("b_cnt14", {28'b0, scB}, 32'd14);
      for (int i = 0; i < 6; i++) step();
      mwB = 1'b0;
      chk("sat_cnt", {28'b0, scB}, 32'd15);
      chk("sat_done", {31'b0, doneB}, 32'd0);
      chk("sat_mis", {31'b0, misB}, 32'd1);

      // C: timeout after edge 19, one store at edge 5
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int e = 0; e < 19; e++) begin
         mwC = (e == 5); adC = 32'h40; wdC = 32'h5;
         step();
      end
      mwC = 1'b0;
      chk("to_pre", {31'b0, toC}, 32'd0);
      chk("to_pre_d", {31'b0, doneC}, 32'd0);
      step();
      chk("to_set", {31'b0, toC}, 32'd1);
      chk("to_done", {31'b0, doneC}, 32'd1);
      chk("to_pass", {31'b0, passC}, 32'd0);
      chk("to_cnt", {16'b0, scC}, 32'd1);
      mwC = 1'b1; adC = 32'd84; wdC = 32'd8;
      step();
      mwC = 1'b0;
      chk("to_frz_c", {16'b0, scC}, 32'd1);
      chk("to_frz_t", {31'b0, toC}, 32'd1);
      chk("to_frz_p", {31'b0, passC}, 32'd0);
      chk("to_frz_s", svC, 32'd0);

      // C: signature on the timeout cycle wins
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int e = 0; e < 19; e++) step();
      chk("tie_pre", {31'b0, doneC}, 32'd0);
      mwC = 1'b1; adC = 32'd84; wdC = 32'd8;
      step();
      mwC = 1'b0;
      chk("tie_pass", {31'b0, passC}, 32'd1);
      chk("tie_to", {31'b0, toC}, 32'd0);
      chk("tie_sig", svC, 32'd8);
      step();
      chk("tie_hold", {31'b0, toC}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
